// File: rtl/gate_response_checker.sv
// gate_response_checker
//
// Self-checking driver for an N-input combinational gate. After a start pulse
// the block latches the expected truth table and then steps through every
// input vector in ascending order. Each vector is held for SETTLE_CYCLES
// cycles and then sampled for one cycle. The result is a saturating mismatch
// count, the first failing vector and a pass flag.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   start            single-cycle run request, ignored while busy
//   expect_tt        expected truth table; bit i is the expected y for vector i
//   dut_y            output of the gate under test
//   stim             registered input vector driven to the gate
//   busy             run in progress
//   done             run finished, held until the next accepted start or reset
//   pass             done with zero mismatches
//   err_count        saturating mismatch count
//   first_fail_vec   vector of the first mismatch
//   first_fail_valid first_fail_vec holds a captured value
//
// State table:
//   state     | meaning
//   ST_IDLE   | waiting for the first start after reset
//   ST_SETTLE | holding stim steady while the gate output settles
//   ST_SAMPLE | comparing dut_y against the latched table for this vector
//   ST_DONE   | run complete, results held, start accepted again

module gate_response_checker #(
    parameter int N_INPUTS      = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [2**N_INPUTS-1:0] expect_tt,
    input  logic                   dut_y,
    output logic [N_INPUTS-1:0]    stim,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_W-1:0]       err_count,
    output logic [N_INPUTS-1:0]    first_fail_vec,
    output logic                   first_fail_valid
);

    localparam int                  N_VEC       = 2**N_INPUTS;
    localparam logic [N_INPUTS-1:0] LAST_VEC    = {N_INPUTS{1'b1}};
    localparam logic [7:0]          SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N_VEC-1:0] tt_q;
    logic [7:0]       settle_cnt;

    logic accept;
    logic settle_dec;
    logic sample_en;
    logic finish;
    logic mismatch;
    logic last_vec;

    // busy is still high during the first DONE cycle (results are published
    // one edge after DONE is entered), so gating on it keeps a start in that
    // cycle from being accepted before the results appear.
    assign accept   = start && !busy && ((state == ST_IDLE) || (state == ST_DONE));
    assign mismatch = (dut_y != tt_q[stim]);
    assign last_vec = (stim == LAST_VEC);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == 8'd0) state_nxt = ST_SAMPLE;
            ST_SAMPLE: state_nxt = last_vec ? ST_DONE : ST_SETTLE;
            ST_DONE:   if (accept) state_nxt = ST_SETTLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Control strobes decoded from the state
    always_comb begin
        settle_dec = 1'b0;
        sample_en  = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_SETTLE: settle_dec = (settle_cnt != 8'd0);
            ST_SAMPLE: sample_en  = 1'b1;
            ST_DONE:   finish     = busy;
            default:   ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_q             <= '0;
            settle_cnt       <= 8'd0;
            stim             <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (accept) begin
            tt_q             <= expect_tt;
            settle_cnt       <= SETTLE_LOAD;
            stim             <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            if (settle_dec) begin
                settle_cnt <= settle_cnt - 8'd1;
            end
            if (sample_en) begin
                if (mismatch) begin
                    if (err_count != {ERR_W{1'b1}}) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (!first_fail_valid) begin
                        first_fail_vec   <= stim;
                        first_fail_valid <= 1'b1;
                    end
                end
                // stim stops at the last vector so it never wraps within a run
                if (!last_vec) begin
                    stim       <= stim + 1'b1;
                    settle_cnt <= SETTLE_LOAD;
                end
            end
            if (finish) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (err_count == '0);
            end
        end
    end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
- Synthesizable self-checking block for N-input combinational gates.
- Drives every input vector in order onto the gate under test. Waits a fixed settle time, then samples the gate output and compares it with a truth table supplied at start.
- Reports pass/fail, a mismatch count and the first failing vector.
- Sits next to a gate instance in the logic-gates area and replaces a simulation-only stimulus/monitor loop.

Parameters:
- N_INPUTS, 2, number of gate inputs; legal 1..4.
- SETTLE_CYCLES, 2, cycles a vector is held before sampling; legal 1..255.
- ERR_W, 8, width of the mismatch counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a run.
- expect_tt  input  2**N_INPUTS  expected output; bit i is the expected y for input vector i.
- dut_y  input  1  output of the gate under test.
- stim  output  N_INPUTS  input vector driven to the gate; registered.
- busy  output  1  run in progress.
- done  output  1  run finished; held until the next accepted start or reset.
- pass  output  1  done and zero mismatches.
- err_count  output  ERR_W  saturating mismatch count.
- first_fail_vec  output  N_INPUTS  vector of the first mismatch.
- first_fail_valid  output  1  first_fail_vec holds a captured value.

Behaviour:
- Reset: asynchronous on rst_n low. All outputs go to 0 and state goes to IDLE. Deassertion is used synchronously by the design.
- States and transitions:
  - IDLE/DONE: start=1 moves to SETTLE on the next edge.
  - SETTLE: counts down and moves to SAMPLE when the count is exhausted.
  - SAMPLE: moves to SETTLE with the next vector, or to DONE after the last vector.
- Start accepted in IDLE or DONE (edge k):
  - expect_tt latched into an internal register; later changes to the port are ignored for the rest of the run.
  - stim=0, err_count=0, first_fail_valid=0, first_fail_vec=0, done=0, pass=0, busy=1.
  - Settle counter loaded with SETTLE_CYCLES-1.
- Start while busy: ignored, no side effects.
- SETTLE: stim is held stable for SETTLE_CYCLES cycles.
- SAMPLE (one cycle per vector):
  - dut_y is compared with latched_tt[stim].
  - On mismatch: err_count increments and saturates at 2**ERR_W-1. If first_fail_valid=0, capture first_fail_vec=stim and set first_fail_valid=1.
  - If stim == 2**N_INPUTS-1: go to DONE.
  - Otherwise: stim increments by 1 and the settle counter reloads.
- Timing:
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - done rises at edge k + 2**N_INPUTS*(SETTLE_CYCLES+1) + 1.
  - busy falls on the same edge.
- DONE:
  - done=1 and pass=(err_count==0).
  - stim holds the last vector.
  - err_count and first_fail_* hold their values.
- Boundary conditions:
  - stim never wraps within a run.
  - The final-vector mismatch is counted before done rises.
  - A start in the same cycle that DONE is entered is not seen; start is only sampled while in IDLE/DONE.
  - Reset mid-run aborts immediately: all outputs 0, no partial results kept.
- No combinational path from any input to any output.

Test Plan:
- AND gate (y=a&b, stim[1]=a, stim[0]=b), expect_tt=4'b1000, SETTLE_CYCLES=2, single start pulse -> stim steps 0,1,2,3 holding 3 cycles each; done=1 and pass=1 exactly 13 cycles after start; err_count=0; first_fail_valid=0.
- dut_y tied 0, expect_tt=4'b1000 -> done=1, pass=0, err_count=1, first_fail_vec=2'b11, first_fail_valid=1.
- AND gate, expect_tt=4'b1110 (OR table) -> err_count=2, first_fail_vec=2'b01, pass=0.
- Start pulsed again at cycle 5 of a run, and expect_tt changed mid-run -> no restart; done still at cycle 13; result matches the tt latched at the original start.
- rst_n low for 1 cycle during vector 2 -> all outputs 0 immediately (asynchronous); new start afterwards gives a clean 13-cycle run with correct results.
- N_INPUTS=3, ERR_W=2, dut_y = ~latched expected (all 8 wrong) -> err_count saturates at 3, first_fail_vec=0; a second start from DONE clears err_count to 0 on the first cycle.
